display_ctrl: RTL and testbench
===============================

// Module: display_ctrl
// PURPOSE
//  Parametrised front-panel driver for the processor; sits between the datapath and the board LEDs/HEX.
//  Registers the bus, one of NUM_REGS registers, the timestep and DONE into a stable display image.
//  Adds a register-select button, display hold, a latched DONE blink and leading-zero blanking.
//  All outputs are registered or decoded from registered state; no output is combinational from an input.
// PARAMETERS
//  DATA_W      10  bus/register width; NUM_DIGITS = (DATA_W+3)/4 hex digits
//  NUM_REGS    4   registers selectable for display, >=2
//  TIME_W      2   timestep width, 1..4
//  BLINK_DIV   25_000_000  half-period of LED_D blink, in clocks, >=2
//  BLANK_LZ    1   1: blank leading-zero digits (digit 0 never blanked)
// PORTS
//  CLK       in   1                  system clock, rising edge
//  RSTb      in   1                  asynchronous active-low reset
//  BUS       in   DATA_W             processor bus
//  REG_FLAT  in   NUM_REGS*DATA_W    register file, reg i = [i*DATA_W +: DATA_W]
//  TIME      in   TIME_W             current timestep
//  PEEKb     in   1                  1: show BUS; 0: show REG[SEL_IDX]
//  SEL_NEXTb in   1                  raw active-low pushbutton, asynchronous to CLK
//  HOLD      in   1                  1: freeze the HEX display value
//  DONE      in   1                  instruction-complete level
//  CLR_DONE  in   1                  synchronous clear of the DONE latch
//  LED_B     out  DATA_W             registered BUS
//  DHEX      out  NUM_DIGITS*7       digit i = [i*7 +: 7], active-low segments
//  THEX      out  7                  timestep digit, active-low
//  LED_D     out  1                  DONE indicator
//  SEL_IDX   out  $clog2(NUM_REGS)   currently selected register
// BEHAVIOUR
//  Reset (async, RSTb=0): disp_q=0, LED_B=0, time_q=0, SEL_IDX=0, done_lat=0, blink_cnt=0, LED_D=0.
//   During reset, DHEX digit0 and THEX show "0" (7'b1000000).
//   During reset, DHEX digits >0 show blank (7'h7F) if BLANK_LZ, else "0".
//   Button sync flops reset to 1 (released), so releasing reset never yields a press.
//  Select: SEL_NEXTb -> 2-flop sync -> falling-edge detect (prev=1, now=0) = one-cycle press.
//   press: SEL_IDX <= (SEL_IDX==NUM_REGS-1) ? 0 : SEL_IDX+1.
//   Latency: button sampled low at edge k -> SEL_IDX changes at edge k+2.
//   Holding the button gives exactly one increment; presses count in both PEEKb modes.
//  Display: each edge with HOLD=0: disp_q <= PEEKb ? BUS : REG[SEL_IDX]. HOLD=1: disp_q keeps its value.
//   DHEX is decoded from disp_q, so input -> DHEX latency = 1 clock.
//   Digit i shows disp_q[4i+3:4i]; the top digit is zero-extended (DATA_W=10: {2'b0, v[9:8]}).
//   BLANK_LZ: digit i>0 is blank iff it and all higher digits are zero.
//  LED_B <= BUS every edge; HOLD has no effect on it. time_q <= TIME; THEX = decode({0, time_q}).
//  DONE latch: done_prev <= DONE; rise = DONE & ~done_prev.
//   rise sets done_lat. CLR_DONE clears it. rise and CLR_DONE in the same cycle: set wins.
//   LED_D: DONE level high -> 1.
//   LED_D: else done_lat=1 -> blink: toggles every BLINK_DIV clocks, first toggle to 0 after BLINK_DIV.
//   LED_D: else -> 0.
//   blink_cnt runs only while done_lat=1 and DONE=0; it is zeroed when done_lat clears or DONE rises.
//  Hex decode: 0-9, A-F standard; values never invalid, so no default error glyph is needed.
// STRUCTURE
//  Package disp_pkg:
//   SEG_BLANK=7'h7F, SEG_ZERO=7'b1000000
//   function hex2seg(logic [3:0]) -> logic [6:0]
//   localparam-style helper for NUM_DIGITS
//  Sub-module seg_decoder (4-bit in, blank in, 7-bit out), instantiated NUM_DIGITS+1 times via generate.
//  All other logic stays in display_ctrl: button sync/edge, SEL_IDX counter, disp/time/LED_B regs, DONE latch + blink counter.
// TESTING (defaults; BLINK_DIV=4 in bench)
//  1 Reset: assert RSTb=0 mid-run with disp_q=0x3FF.
//    -> Immediately: DHEX = {7F,7F,40}, THEX=40, LED_D=0, SEL_IDX=0.
//    -> After release, no SEL_IDX change.
//  2 Source select: PEEKb=1, BUS=0x2A5.
//    -> Next edge: DHEX = {"2","A","5"}, LED_B=0x2A5.
//    -> PEEKb=0, REG0=0x007: DHEX = {7F,7F,"7"}.
//  3 Select wrap: 4 presses of SEL_NEXTb, each held 10 clks.
//    -> SEL_IDX 1,2,3,0, each 2 edges after sampled low.
//    -> A 1-clk glitch shorter than sampling yields at most one step.
//  4 HOLD: HOLD=1, then change BUS 0x100 -> 0x0FF.
//    -> DHEX stays "100"; LED_B tracks 0x0FF.
//    -> HOLD=0: DHEX shows {7F,"F","F"} next edge.
//  5 DONE latch: pulse DONE for 1 clk.
//    -> LED_D=1 during the pulse, then 0 for 4 clks, 1 for 4 clks, repeating.
//    -> CLR_DONE -> LED_D=0 next edge.
//    -> DONE rise with CLR_DONE in the same cycle: latch stays set.
//  6 TIME sweep 0..3: THEX = "0","1","2","3", each 1 clk after input.

Source files
------------

// File: rtl/display_ctrl_pkg.sv
// Shared constants and the hex-to-seven-segment mapping for the front-panel driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic int num_digits(input int data_w);
    return (data_w + 3) / 4;
  endfunction

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = SEG_ZERO;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_ctrl_seg_decoder.sv
// One seven-segment digit: hex value to active-low segments, with a blank override.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex2seg(val);

endmodule

// File: rtl/display_ctrl.sv
// Front-panel driver: registers bus/register/timestep/DONE into a stable LED and HEX image,
// with a debounced-by-sync register-select button, display hold and a latched DONE blink.
module display_ctrl
  import disp_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int NUM_REGS  = 4,
  parameter int TIME_W    = 2,
  parameter int BLINK_DIV = 25_000_000,
  parameter int BLANK_LZ  = 1
) (
  input  logic                               CLK,
  input  logic                               RSTb,
  input  logic [DATA_W-1:0]                  BUS,
  input  logic [NUM_REGS*DATA_W-1:0]         REG_FLAT,
  input  logic [TIME_W-1:0]                  TIME,
  input  logic                               PEEKb,
  input  logic                               SEL_NEXTb,
  input  logic                               HOLD,
  input  logic                               DONE,
  input  logic                               CLR_DONE,
  output logic [DATA_W-1:0]                  LED_B,
  output logic [num_digits(DATA_W)*7-1:0]    DHEX,
  output logic [6:0]                         THEX,
  output logic                               LED_D,
  output logic [$clog2(NUM_REGS)-1:0]        SEL_IDX
);

  localparam int NUM_DIGITS = num_digits(DATA_W);
  localparam int PAD_W      = NUM_DIGITS * 4;
  localparam int SEL_W      = $clog2(NUM_REGS);
  localparam int CNT_W      = $clog2(BLINK_DIV);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              btn_prev_q, btn_prev_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] led_b_q, led_b_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              done_prev_q, done_prev_d;
  logic              done_lat_q, done_lat_d;
  logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              press;
  logic              rise;

  logic [DATA_W-1:0] reg_arr [NUM_REGS];
  logic [PAD_W-1:0]  disp_pad;
  logic [3:0]        time_nib;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign reg_arr[r] = REG_FLAT[r*DATA_W +: DATA_W];
  end

  always_comb begin
    sync1_d     = SEL_NEXTb;
    sync2_d     = sync1_q;
    btn_prev_d  = sync2_q;
    press       = btn_prev_q & ~sync2_q;
    sel_d       = sel_q;
    disp_d      = disp_q;
    led_b_d     = BUS;
    time_d      = TIME;
    done_prev_d = DONE;
    rise        = DONE & ~done_prev_q;
    done_lat_d  = done_lat_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (press) begin
      sel_d = (sel_q == SEL_W'(NUM_REGS - 1)) ? '0 : sel_q + 1'b1;
    end

    if (!HOLD) begin
      disp_d = PEEKb ? BUS : reg_arr[sel_q];
    end

    // Set has priority over clear so a completion is never lost.
    if (CLR_DONE) done_lat_d = 1'b0;
    if (rise)     done_lat_d = 1'b1;

    // Blink phase starts dark; it only advances while the registered DONE level is low.
    if (rise || !done_lat_d) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (done_lat_q && !done_prev_q) begin
      if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      btn_prev_q  <= 1'b1;
      sel_q       <= '0;
      disp_q      <= '0;
      led_b_q     <= '0;
      time_q      <= '0;
      done_prev_q <= 1'b0;
      done_lat_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_prev_q  <= btn_prev_d;
      sel_q       <= sel_d;
      disp_q      <= disp_d;
      led_b_q     <= led_b_d;
      time_q      <= time_d;
      done_prev_q <= done_prev_d;
      done_lat_q  <= done_lat_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign LED_B   = led_b_q;
  assign SEL_IDX = sel_q;
  assign LED_D   = done_prev_q | (done_lat_q & blink_ph_q);

  assign disp_pad = PAD_W'(disp_q);
  assign time_nib = 4'(time_q);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic blank;
    assign blank = (BLANK_LZ != 0) && (i != 0) && (disp_pad[PAD_W-1:4*i] == '0);
    seg_decoder u_dec (
      .val   (disp_pad[4*i +: 4]),
      .blank (blank),
      .seg   (DHEX[7*i +: 7])
    );
  end

  seg_decoder u_time_dec (
    .val   (time_nib),
    .blank (1'b0),
    .seg   (THEX)
  );

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl with BLINK_DIV shortened to 4.
module tb_display_ctrl;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, SA = 7'h08, SC = 7'h46;
  localparam logic [6:0] SF = 7'h0E, BL = 7'h7F;

  logic        CLK;
  logic        RSTb;
  logic [9:0]  BUS;
  logic [39:0] REG_FLAT;
  logic [1:0]  TIME;
  logic        PEEKb, SEL_NEXTb, HOLD, DONE, CLR_DONE;
  logic [9:0]  LED_B;
  logic [20:0] DHEX;
  logic [6:0]  THEX;
  logic        LED_D;
  logic [1:0]  SEL_IDX;

  int checks   = 0;
  int failures = 0;

  display_ctrl #(
    .DATA_W(10), .NUM_REGS(4), .TIME_W(2), .BLINK_DIV(4), .BLANK_LZ(1)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .BUS(BUS), .REG_FLAT(REG_FLAT), .TIME(TIME),
    .PEEKb(PEEKb), .SEL_NEXTb(SEL_NEXTb), .HOLD(HOLD), .DONE(DONE),
    .CLR_DONE(CLR_DONE), .LED_B(LED_B), .DHEX(DHEX), .THEX(THEX),
    .LED_D(LED_D), .SEL_IDX(SEL_IDX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [20:0] dh(input logic [6:0] d2, input logic [6:0] d1,
                                     input logic [6:0] d0);
    return {d2, d1, d0};
  endfunction

  logic [20:0] reg_img [4];
  logic [1:0]  exp_sel;
  logic [6:0]  t_seg [4];

  initial begin
    reg_img[0] = dh(BL, BL, S7);   // 0x007
    reg_img[1] = dh(S3, SF, SF);   // 0x3FF
    reg_img[2] = dh(BL, S1, S2);   // 0x012
    reg_img[3] = dh(BL, SC, S0);   // 0x0C0
    t_seg[0] = S0; t_seg[1] = S1; t_seg[2] = S2; t_seg[3] = S3;

    RSTb = 1'b0; BUS = '0; TIME = '0; PEEKb = 1'b1; SEL_NEXTb = 1'b1;
    HOLD = 1'b0; DONE = 1'b0; CLR_DONE = 1'b0;
    REG_FLAT = {10'h0C0, 10'h012, 10'h3FF, 10'h007};
    #1;
    chk("rst_dhex", 32'(DHEX), 32'(dh(BL, BL, S0)));
    chk("rst_thex", 32'(THEX), 32'(S0));
    chk("rst_ledb", 32'(LED_B), 32'h0);
    chk("rst_ledd", 32'(LED_D), 32'h0);
    chk("rst_sel",  32'(SEL_IDX), 32'h0);
    tick(); tick();
    RSTb = 1'b1;
    tick(); tick();

    // Source select
    BUS = 10'h2A5; PEEKb = 1'b1;
    tick();
    chk("peek_dhex", 32'(DHEX), 32'(dh(S2, SA, S5)));
    chk("peek_ledb", 32'(LED_B), 32'h2A5);
    PEEKb = 1'b0;
    tick();
    chk("reg0_dhex", 32'(DHEX), 32'(reg_img[0]));

    // Select wrap with long presses
    exp_sel = 2'd0;
    for (int p = 0; p < 4; p++) begin
      SEL_NEXTb = 1'b0;
      tick();
      chk("sel_k", 32'(SEL_IDX), 32'(exp_sel));
      tick();
      chk("sel_k1", 32'(SEL_IDX), 32'(exp_sel));
      tick();
      exp_sel = exp_sel + 2'd1;
      chk("sel_k2", 32'(SEL_IDX), 32'(exp_sel));
      for (int h = 0; h < 7; h++) tick();
      SEL_NEXTb = 1'b1;
      for (int h = 0; h < 4; h++) tick();
      chk("sel_held", 32'(SEL_IDX), 32'(exp_sel));
      chk("sel_dhex", 32'(DHEX), 32'(reg_img[exp_sel]));
    end
    chk("sel_wrap", 32'(SEL_IDX), 32'h0);

    // One-clock glitch gives a single step
    SEL_NEXTb = 1'b0;
    tick();
    SEL_NEXTb = 1'b1;
    for (int h = 0; h < 6; h++) tick();
    chk("glitch_sel", 32'(SEL_IDX), 32'h1);

    // Asynchronous reset mid-run with a full display
    PEEKb = 1'b1; BUS = 10'h3FF; TIME = 2'd3;
    tick();
    chk("pre_rst_dhex", 32'(DHEX), 32'(dh(S3, SF, SF)));
    RSTb = 1'b0;
    #1;
    chk("arst_dhex", 32'(DHEX), 32'(dh(BL, BL, S0)));
    chk("arst_thex", 32'(THEX), 32'(S0));
    chk("arst_ledd", 32'(LED_D), 32'h0);
    chk("arst_sel",  32'(SEL_IDX), 32'h0);
    tick();
    RSTb = 1'b1;
    for (int h = 0; h < 4; h++) tick();
    chk("post_rst_sel", 32'(SEL_IDX), 32'h0);

    // Hold
    BUS = 10'h100; TIME = 2'd0;
    tick();
    chk("hold_pre", 32'(DHEX), 32'(dh(S1, S0, S0)));
    HOLD = 1'b1; BUS = 10'h0FF;
    tick();
    chk("hold_dhex", 32'(DHEX), 32'(dh(S1, S0, S0)));
    chk("hold_ledb", 32'(LED_B), 32'h0FF);
    tick();
    chk("hold_dhex2", 32'(DHEX), 32'(dh(S1, S0, S0)));
    HOLD = 1'b0;
    tick();
    chk("unhold_dhex", 32'(DHEX), 32'(dh(BL, SF, SF)));

    // DONE latch and blink
    DONE = 1'b1;
    tick();
    chk("done_pulse", 32'(LED_D), 32'h1);
    DONE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("blink", 32'(LED_D), (i < 4 || i == 8) ? 32'h0 : 32'h1);
    end
    CLR_DONE = 1'b1;
    tick();
    chk("clr_ledd", 32'(LED_D), 32'h0);
    CLR_DONE = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("clr_stays", 32'(LED_D), 32'h0);
    DONE = 1'b1; CLR_DONE = 1'b1;
    tick();
    chk("setclr_level", 32'(LED_D), 32'h1);
    DONE = 1'b0; CLR_DONE = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("setclr_dark", 32'(LED_D), 32'h0);
    tick();
    chk("setclr_blink", 32'(LED_D), 32'h1);

    // Timestep sweep
    for (int t = 0; t < 4; t++) begin
      TIME = 2'(t);
      tick();
      chk("thex", 32'(THEX), 32'(t_seg[t]));
    end
    TIME = 2'd1;
    #1;
    chk("thex_reg", 32'(THEX), 32'(S3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
